// File: rtl/writeback_arbiter_if.sv
// Writeback bus bundle: producer channels, issue port, register-file write side.
// Bypass signals exist only when WB_BYPASS_EN is defined.
interface writeback_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NUM   = 64,
  parameter int IDXW  = 6
);
  logic                  alu_valid;
  logic [IDXW-1:0]       alu_rd;
  logic [WIDTH-1:0]      alu_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [IDXW-1:0]       mem_rd;
  logic [WIDTH-1:0]      mem_data;
  logic                  fpu_valid;
  logic                  fpu_ready;
  logic [IDXW-1:0]       fpu_rd;
  logic [WIDTH-1:0]      fpu_data;
  logic                  issue_valid;
  logic [IDXW-1:0]       issue_rd;
  logic [WIDTH*NUM-1:0]  inreg;
  logic [NUM-1:0]        enable;
  logic [NUM-1:0]        busy;
`ifdef WB_BYPASS_EN
  logic                  byp_valid;
  logic [IDXW-1:0]       byp_rd;
  logic [WIDTH-1:0]      byp_data;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output mem_ready,
    input  fpu_valid, fpu_rd, fpu_data,
    output fpu_ready,
    input  issue_valid, issue_rd,
    output inreg, enable, busy,
    output byp_valid, byp_rd, byp_data
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  mem_ready,
    output fpu_valid, fpu_rd, fpu_data,
    input  fpu_ready,
    output issue_valid, issue_rd,
    input  inreg, enable, busy,
    input  byp_valid, byp_rd, byp_data
  );
`else
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output mem_ready,
    input  fpu_valid, fpu_rd, fpu_data,
    output fpu_ready,
    input  issue_valid, issue_rd,
    output inreg, enable, busy
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  mem_ready,
    output fpu_valid, fpu_rd, fpu_data,
    input  fpu_ready,
    output issue_valid, issue_rd,
    input  inreg, enable, busy
  );
`endif
endinterface

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: ALU > MEM > FPU into a registered one-write-per-cycle port,
// with MEM/FPU skid buffers and a pending-destination scoreboard. Optional: WB_BYPASS_EN.
module writeback_arbiter #(
  parameter int WIDTH = 32,
  parameter int NUM   = 64,
  parameter int IDXW  = 6
) (
  input logic clk,
  input logic rst,
  writeback_arbiter_if.slave bus
);

  typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_MEM, SRC_FPU} src_t;

  logic              mem_full;
  logic [IDXW-1:0]   mem_buf_rd;
  logic [WIDTH-1:0]  mem_buf_data;
  logic              fpu_full;
  logic [IDXW-1:0]   fpu_buf_rd;
  logic [WIDTH-1:0]  fpu_buf_data;

  logic              mem_xfer;
  logic              fpu_xfer;
  logic              mem_cand;
  logic              fpu_cand;
  logic [IDXW-1:0]   mem_cand_rd;
  logic [WIDTH-1:0]  mem_cand_data;
  logic [IDXW-1:0]   fpu_cand_rd;
  logic [WIDTH-1:0]  fpu_cand_data;

  src_t              win_src;
  logic [IDXW-1:0]   win_rd;
  logic [WIDTH-1:0]  win_data;
  logic              win_valid;
  logic              win_writes;
  logic              issue_sets;
  logic [NUM-1:0]    win_onehot;
  logic [NUM-1:0]    issue_onehot;

  logic [WIDTH*NUM-1:0] inreg_q;
  logic [NUM-1:0]       enable_q;
  logic [NUM-1:0]       busy_q;

  assign bus.mem_ready = !mem_full;
  assign bus.fpu_ready = !fpu_full;
  assign bus.inreg     = inreg_q;
  assign bus.enable    = enable_q;
  assign bus.busy      = busy_q;

  // A buffered entry always takes precedence over (and blocks) a live transfer.
  always_comb begin
    mem_xfer      = bus.mem_valid && !mem_full;
    fpu_xfer      = bus.fpu_valid && !fpu_full;
    mem_cand      = mem_full || mem_xfer;
    fpu_cand      = fpu_full || fpu_xfer;
    mem_cand_rd   = mem_full ? mem_buf_rd   : bus.mem_rd;
    mem_cand_data = mem_full ? mem_buf_data : bus.mem_data;
    fpu_cand_rd   = fpu_full ? fpu_buf_rd   : bus.fpu_rd;
    fpu_cand_data = fpu_full ? fpu_buf_data : bus.fpu_data;
  end

  always_comb begin
    win_src  = SRC_NONE;
    win_rd   = '0;
    win_data = '0;
    if (bus.alu_valid) begin
      win_src  = SRC_ALU;
      win_rd   = bus.alu_rd;
      win_data = bus.alu_data;
    end else if (mem_cand) begin
      win_src  = SRC_MEM;
      win_rd   = mem_cand_rd;
      win_data = mem_cand_data;
    end else if (fpu_cand) begin
      win_src  = SRC_FPU;
      win_rd   = fpu_cand_rd;
      win_data = fpu_cand_data;
    end
  end

  // Index 0 and out-of-range indices still consume the slot but never write.
  always_comb begin
    win_valid    = (win_src != SRC_NONE);
    win_writes   = win_valid && (win_rd != '0) && (int'(win_rd) < NUM);
    issue_sets   = bus.issue_valid && (bus.issue_rd != '0) && (int'(bus.issue_rd) < NUM);
    win_onehot   = win_writes ? (NUM'(1) << win_rd) : '0;
    issue_onehot = issue_sets ? (NUM'(1) << bus.issue_rd) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_full     <= 1'b0;
      mem_buf_rd   <= '0;
      mem_buf_data <= '0;
    end else if (mem_full && win_src == SRC_MEM) begin
      mem_full <= 1'b0;
    end else if (mem_xfer && win_src != SRC_MEM) begin
      mem_full     <= 1'b1;
      mem_buf_rd   <= bus.mem_rd;
      mem_buf_data <= bus.mem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpu_full     <= 1'b0;
      fpu_buf_rd   <= '0;
      fpu_buf_data <= '0;
    end else if (fpu_full && win_src == SRC_FPU) begin
      fpu_full <= 1'b0;
    end else if (fpu_xfer && win_src != SRC_FPU) begin
      fpu_full     <= 1'b1;
      fpu_buf_rd   <= bus.fpu_rd;
      fpu_buf_data <= bus.fpu_data;
    end
  end

  // A new issue to the same register outranks the retiring write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q <= '0;
      inreg_q  <= '0;
      busy_q   <= '0;
    end else begin
      enable_q <= win_onehot;
      if (win_valid) inreg_q <= {NUM{win_data}};
      busy_q   <= (busy_q & ~win_onehot) | issue_onehot;
    end
  end

`ifdef WB_BYPASS_EN
  assign bus.byp_valid = win_writes;
  assign bus.byp_rd    = win_rd;
  assign bus.byp_data  = win_data;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized bench for writeback_arbiter against a queue-based reference model.
module tb_writeback_arbiter;
  localparam int WIDTH = 32;
  localparam int NUM   = 64;
  localparam int IDXW  = 6;

  typedef struct {
    bit               valid;
    logic [IDXW-1:0]  rd;
    logic [WIDTH-1:0] data;
  } result_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  writeback_arbiter_if #(.WIDTH(WIDTH), .NUM(NUM), .IDXW(IDXW)) bus ();

  writeback_arbiter #(.WIDTH(WIDTH), .NUM(NUM), .IDXW(IDXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  result_t          memQ[$];
  result_t          fpuQ[$];
  logic [NUM-1:0]   expEnable;
  logic [NUM-1:0]   expBusy;
  logic [WIDTH-1:0] expData;
  int               checkSlice = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("enable", 64'(bus.enable), 64'(expEnable));
    checkOutput("busy", 64'(bus.busy), 64'(expBusy));
    checkOutput("inreg_slice", 64'(bus.inreg[checkSlice*WIDTH +: WIDTH]), 64'(expData));
    checkOutput("mem_ready", 64'(bus.mem_ready), 64'(memQ.size() == 0));
    checkOutput("fpu_ready", 64'(bus.fpu_ready), 64'(fpuQ.size() == 0));
    checkSlice = (checkSlice + 7) % NUM;
  endtask

  task automatic modelReset();
    memQ.delete();
    fpuQ.delete();
    expEnable = '0;
    expBusy   = '0;
    expData   = '0;
  endtask

  // Asynchronous reset raised between edges; outputs must clear without a clock.
  task automatic doReset();
    rst = 1'b1;
    modelReset();
    #1;
    checkAll();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic applyStimulus(
    input bit aV, input logic [IDXW-1:0] aRd, input logic [WIDTH-1:0] aD,
    input bit mV, input logic [IDXW-1:0] mRd, input logic [WIDTH-1:0] mD,
    input bit fV, input logic [IDXW-1:0] fRd, input logic [WIDTH-1:0] fD,
    input bit iV, input logic [IDXW-1:0] iRd);
    result_t cand[3];
    int      winIdx;
    bit      memLive;
    bit      fpuLive;
    bus.alu_valid = aV;  bus.alu_rd = aRd;  bus.alu_data = aD;
    bus.mem_valid = mV;  bus.mem_rd = mRd;  bus.mem_data = mD;
    bus.fpu_valid = fV;  bus.fpu_rd = fRd;  bus.fpu_data = fD;
    bus.issue_valid = iV;  bus.issue_rd = iRd;
    memLive = mV && (memQ.size() == 0);
    fpuLive = fV && (fpuQ.size() == 0);
    cand[0] = '{aV, aRd, aD};
    cand[1] = (memQ.size() != 0) ? memQ[0] : result_t'{memLive, mRd, mD};
    cand[2] = (fpuQ.size() != 0) ? fpuQ[0] : result_t'{fpuLive, fRd, fD};
    winIdx = -1;
    for (int i = 0; i < 3; i++)
      if (winIdx < 0 && cand[i].valid) winIdx = i;
`ifdef WB_BYPASS_EN
    #1;
    checkOutput("byp_valid", 64'(bus.byp_valid), 64'(winIdx >= 0 && cand[winIdx >= 0 ? winIdx : 0].rd != 0));
    if (winIdx >= 0 && cand[winIdx].rd != 0) begin
      checkOutput("byp_rd", 64'(bus.byp_rd), 64'(cand[winIdx].rd));
      checkOutput("byp_data", 64'(bus.byp_data), 64'(cand[winIdx].data));
    end
`endif
    expEnable = '0;
    if (winIdx >= 0) begin
      expData = cand[winIdx].data;
      if (cand[winIdx].rd != 0) begin
        expEnable = NUM'(1) << cand[winIdx].rd;
        expBusy[cand[winIdx].rd] = 1'b0;
      end
    end
    if (iV && iRd != 0) expBusy[iRd] = 1'b1;
    if (memQ.size() != 0 && winIdx == 1) void'(memQ.pop_front());
    else if (memLive && winIdx != 1) memQ.push_back(cand[1]);
    if (fpuQ.size() != 0 && winIdx == 2) void'(fpuQ.pop_front());
    else if (fpuLive && winIdx != 2) fpuQ.push_back(cand[2]);
    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.alu_valid = 0;  bus.alu_rd = '0;  bus.alu_data = '0;
    bus.mem_valid = 0;  bus.mem_rd = '0;  bus.mem_data = '0;
    bus.fpu_valid = 0;  bus.fpu_rd = '0;  bus.fpu_data = '0;
    bus.issue_valid = 0;  bus.issue_rd = '0;
    @(negedge clk);
    doReset();

    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_enable", 64'(bus.enable), 64'h20);
    checkOutput("t1_data", 64'(bus.inreg[5*WIDTH +: WIDTH]), 64'hDEADBEEF);
    idle();
    checkOutput("t1_enable_off", 64'(bus.enable), 64'h0);

    applyStimulus(1, 3, 32'h11, 1, 4, 32'h22, 1, 40, 32'h33, 0, 0);
    checkOutput("t2_r3", 64'(bus.enable), 64'h8);
    checkOutput("t2_mem_ready_low", 64'(bus.mem_ready), 64'h0);
    idle();
    checkOutput("t2_r4", 64'(bus.enable), 64'h10);
    checkOutput("t2_mem_ready_high", 64'(bus.mem_ready), 64'h1);
    checkOutput("t2_fpu_ready_low", 64'(bus.fpu_ready), 64'h0);
    idle();
    checkOutput("t2_f8", 64'(bus.enable), 64'h0000_0100_0000_0000);
    checkOutput("t2_f8_data", 64'(bus.inreg[40*WIDTH +: WIDTH]), 64'h33);
    checkOutput("t2_fpu_ready_high", 64'(bus.fpu_ready), 64'h1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 32'h5555, 0, 0, 0, 1, 33, 32'h77, 0, 0);
      checkOutput("t3_r0_silent", 64'(bus.enable), 64'h0);
    end
    idle();
    checkOutput("t3_f1", 64'(bus.enable), 64'h2_0000_0000);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
    checkOutput("t4_busy_set", 64'(bus.busy[7]), 64'h1);
    idle();
    checkOutput("t4_busy_hold", 64'(bus.busy[7]), 64'h1);
    applyStimulus(1, 7, 32'h70, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_busy_clear", 64'(bus.busy[7]), 64'h0);
    applyStimulus(1, 7, 32'h71, 0, 0, 0, 0, 0, 0, 1, 7);
    checkOutput("t4_set_wins", 64'(bus.busy[7]), 64'h1);

    applyStimulus(1, 2, 32'h2, 1, 10, 32'hA, 1, 50, 32'h50, 1, 12);
    doReset();
    idle();
    checkOutput("t5_no_write", 64'(bus.enable), 64'h0);

    applyStimulus(0, 0, 0, 1, 9, 32'hABCD, 0, 0, 0, 0, 0);
    checkOutput("t6_r9", 64'(bus.enable), 64'h200);

    for (int c = 0; c < 600; c++) begin
      if (c == 300) doReset();
      applyStimulus($urandom_range(0, 2) == 0, IDXW'($urandom_range(0, NUM-1)), $urandom,
                    $urandom_range(0, 1) == 1, IDXW'($urandom_range(0, NUM-1)), $urandom,
                    $urandom_range(0, 1) == 1, IDXW'($urandom_range(0, NUM-1)), $urandom,
                    $urandom_range(0, 1) == 1, IDXW'($urandom_range(0, NUM-1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writeback stage directly upstream of the register file. Feeds its flat write-data bus and per-register write-enable vector.
- Merges results from three producers: ALU (single-cycle), MEM (load return) and FPU (multi-cycle). Emits at most one register write per cycle.
- Tracks outstanding destinations in a scoreboard so issue logic can stall on pending registers.

Parameters:
- WIDTH, 32, data width of one register.
- NUM, 64, register count; indices 0-31 are integer r0-r31, 32-63 are f0-f31; index 0 is hard-wired zero.
- IDXW, 6, register index width; must satisfy 2**IDXW >= NUM.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- alu_valid  input  1  ALU result valid; always accepted, no ready.
- alu_rd  input  IDXW  ALU destination index.
- alu_data  input  WIDTH  ALU result.
- mem_valid  input  1  load result valid.
- mem_ready  output  1  MEM channel can accept.
- mem_rd  input  IDXW  load destination.
- mem_data  input  WIDTH  load data.
- fpu_valid  input  1  FPU result valid.
- fpu_ready  output  1  FPU channel can accept.
- fpu_rd  input  IDXW  FPU destination.
- fpu_data  input  WIDTH  FPU result.
- issue_valid  input  1  an instruction with a destination issues this cycle.
- issue_rd  input  IDXW  its destination index.
- inreg  output  WIDTH*NUM  register-file write data; the winning data is replicated into every WIDTH slice.
- enable  output  NUM  one-hot (or zero) write enable; bit k writes register k.
- busy  output  NUM  scoreboard: bit k set while register k has a write in flight.

Behaviour:
- Reset (async, rst=1): enable=0, inreg=0, busy=0, both skid buffers empty, mem_ready=1, fpu_ready=1. Reset mid-operation discards buffered results and pending bits.
- Each of MEM and FPU has a one-entry skid buffer. ready = buffer empty. A transfer occurs when valid&ready.
- Candidates each cycle:
  - ALU: alu_valid.
  - MEM: buffered entry if full, else the live transfer.
  - FPU: same as MEM.
- Fixed priority ALU > MEM > FPU. Exactly one candidate wins.
- A live MEM/FPU transfer that loses is captured into its buffer that cycle; ready drops the next cycle. A buffered entry that wins is freed; ready=1 the next cycle.
- ALU never stalls. Sustained alu_valid starves MEM/FPU by design; issue logic must insert a bubble when busy shows a pending MEM/FPU destination.
- Output register: the winner's enable bit and data appear at the next clock edge, and enable is held for exactly one cycle.
  - ALU latency: valid at edge t, write pulse after edge t+1.
  - MEM/FPU latency: same when the transfer wins immediately; otherwise one extra cycle per lost arbitration.
- Destination index 0: the candidate still wins and consumes its slot, but enable stays 0 (r0 is never written). Index >= NUM behaves the same as index 0.
- No winner in a cycle: enable=0 and inreg holds its previous value.
- Scoreboard:
  - issue_valid with issue_rd != 0 sets busy[issue_rd] at the next edge.
  - A winning write to k clears busy[k] at the same edge its enable is registered.
  - Simultaneous set and clear of the same k: set wins, because the new instruction is outstanding.
  - busy[0] is always 0.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: adds outputs byp_valid (1), byp_rd (IDXW), byp_data (WIDTH).
  - These combinationally present the current cycle's arbitration winner, one cycle before the register-file write, for operand forwarding.
  - byp_valid=0 when there is no winner or the winner's rd is 0.
- Undefined: these ports do not exist and no bypass logic is built.

Test Plan:
- Reset, then alu_valid=1, rd=5, data=0xDEADBEEF at edge 1 -> after edge 2 enable=1<<5 for one cycle and inreg slice 5 = 0xDEADBEEF; after edge 3 enable=0.
- Same cycle: alu rd=3 data=0x11, mem rd=4 data=0x22, fpu rd=40 data=0x33 -> writes in order r3, r4, f8 (index 40) on consecutive cycles; mem_ready and fpu_ready low while their entries are buffered, then high again.
- ALU writes to rd=0 for 3 cycles while fpu_valid is held with rd=33 -> enable stays 0 for those cycles; FPU is buffered and its write lands on the cycle after ALU stops.
- Issue rd=7, then the ALU writes rd=7 two cycles later -> busy[7] is 1 for 2 cycles, then 0; issue rd=7 on the same cycle as the writeback of rd=7 -> busy[7] stays 1.
- Assert rst for one cycle while MEM and FPU are both buffered -> enable=0, busy=0, both ready=1 immediately; buffered data is never written.
- With WB_BYPASS_EN: mem rd=9 data=0xABCD wins -> byp_valid=1, byp_rd=9, byp_data=0xABCD in the same cycle, and enable[9] follows the next cycle.
